// File: rtl/lzd_pkg.sv
// Shared helpers for the pipelined leading-zero detector / normaliser.
// Holds the count-width arithmetic and the parameter legality check.
package lzd_pkg;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // The segment tree needs SEG >= 2 and the word must tile exactly into segments.
    function automatic bit params_ok(input int width, input int seg);
        return (seg >= 2) && is_pow2(seg) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/lzd_seg.sv
// Combinational leading-zero detector for one SEG-bit segment, built as a
// halving tree stored heap-style: node n has children 2n (upper half) and 2n+1.
module lzd_seg
    import lzd_pkg::*;
#(
    parameter int SEG = 16,
    localparam int SW = $clog2(SEG)
) (
    input  logic [SEG-1:0] src,
    output logic [SW-1:0]  c,
    output logic           v
);

    logic [SW-1:0] w_c [2*SEG-1:1];
    logic          w_v [2*SEG-1:1];

    genvar gi;
    // Leaf SEG holds the MSB so the left child is always the more significant half.
    for (gi = 0; gi < SEG; gi++) begin : g_leaf
        assign w_v[SEG+gi] = src[SEG-1-gi];
        assign w_c[SEG+gi] = '0;
    end

    for (gi = 1; gi < SEG; gi++) begin : g_node
        localparam int DEPTH = $clog2(gi + 1) - 1;
        localparam int HALF  = SEG >> (DEPTH + 1);
        assign w_v[gi] = w_v[2*gi] | w_v[2*gi+1];
        assign w_c[gi] = w_v[2*gi] ? w_c[2*gi] : (w_c[2*gi+1] + SW'(HALF));
    end

    assign c = w_c[1];
    assign v = w_v[1];

endmodule

// File: rtl/lzd_norm_pipe.sv
// Two-stage leading-zero detector and normaliser with valid/ready on both sides.
// S1 registers per-segment counts; S2 combines them and left-justifies the word.
module lzd_norm_pipe
    import lzd_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int SEG   = 16,
    parameter int TAG_W = 4,
    localparam int CW   = lzd_pkg::cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_cnt,
    output logic             out_nz,
    output logic [WIDTH-1:0] out_norm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NSEG = WIDTH / SEG;
    localparam int SW   = $clog2(SEG);

    if (!params_ok(WIDTH, SEG)) begin : g_param_check
        $error("lzd_norm_pipe: WIDTH must be a multiple of SEG and SEG a power of two >= 2");
    end

    logic [NSEG-1:0][SW-1:0] w_seg_c;
    logic [NSEG-1:0]         w_seg_v;

    genvar gi;
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
        lzd_seg #(.SEG(SEG)) u_seg (
            .src (in_data[gi*SEG +: SEG]),
            .c   (w_seg_c[gi]),
            .v   (w_seg_v[gi])
        );
    end

    logic                    r_s1_valid;
    logic [NSEG-1:0][SW-1:0] r_s1_c;
    logic [NSEG-1:0]         r_s1_v;
    logic [WIDTH-1:0]        r_s1_data;
    logic [TAG_W-1:0]        r_s1_tag;

    logic                    r_s2_valid;
    logic [CW-1:0]           r_s2_cnt;
    logic                    r_s2_nz;
    logic [WIDTH-1:0]        r_s2_norm;
    logic [TAG_W-1:0]        r_s2_tag;

    logic                    w_s2_load;
    logic                    w_s1_load;
    logic [CW-1:0]           w_cnt;
    logic                    w_nz;
    logic [WIDTH-1:0]        w_norm;

    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign w_s1_load = in_valid && (!r_s1_valid || w_s2_load);
    assign in_ready  = !r_s1_valid || w_s2_load;

    // Ascending scan: the highest non-zero segment is the last one to write.
    always_comb begin
        w_cnt = '0;
        w_nz  = 1'b0;
        for (int i = 0; i < NSEG; i++) begin
            if (r_s1_v[i]) begin
                w_cnt = CW'((NSEG - 1 - i) * SEG) + CW'(r_s1_c[i]);
                w_nz  = 1'b1;
            end
        end
    end

    // An all-zero word gives w_cnt = 0, so the shift passes zero through.
    assign w_norm = r_s1_data << w_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_c     <= '0;
            r_s1_v     <= '0;
            r_s1_data  <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_cnt   <= '0;
            r_s2_nz    <= 1'b0;
            r_s2_norm  <= '0;
            r_s2_tag   <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_s1_c     <= w_seg_c;
                r_s1_v     <= w_seg_v;
                r_s1_data  <= in_data;
                r_s1_tag   <= in_tag;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_cnt   <= w_cnt;
                r_s2_nz    <= w_nz;
                r_s2_norm  <= w_norm;
                r_s2_tag   <= r_s1_tag;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_cnt   = r_s2_cnt;
    assign out_nz    = r_s2_nz;
    assign out_norm  = r_s2_norm;
    assign out_tag   = r_s2_tag;

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Scoreboard bench for lzd_norm_pipe (WIDTH=48, SEG=16, TAG_W=4): stimulus pushes
// expected results, a negedge monitor pops and compares on every output transfer.
module tb_lzd_norm_pipe;

    typedef struct {
        logic [5:0]  cnt;
        logic        nz;
        logic [47:0] norm;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_cnt;
    logic        out_nz;
    logic [47:0] out_norm;
    logic [3:0]  out_tag;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   rand_ready_en = 1'b0;

    lzd_norm_pipe #(.WIDTH(48), .SEG(16), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt),
        .out_nz    (out_nz),
        .out_norm  (out_norm),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] c, input logic nz, input logic [47:0] n,
                                input logic [3:0] t);
        exp_t e;
        e.cnt = c; e.nz = nz; e.norm = n; e.tag = t;
        return e;
    endfunction

    // Bit-serial reference: count zeros from the MSB down.
    function automatic exp_t ref_model(input logic [47:0] d, input logic [3:0] t);
        exp_t e;
        bit   found = 1'b0;
        e.cnt = '0;
        for (int i = 47; i >= 0; i--) begin
            if (!found && d[i]) begin
                e.cnt = 6'(47 - i);
                found = 1'b1;
            end
        end
        e.nz   = found;
        e.norm = d << e.cnt;
        e.tag  = t;
        return e;
    endfunction

    logic        prev_stall = 1'b0;
    logic [5:0]  prev_cnt;
    logic        prev_nz;
    logic [47:0] prev_norm;
    logic [3:0]  prev_tag;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'(1'b1));
                chk("stall_cnt",   64'(out_cnt),   64'(prev_cnt));
                chk("stall_nz",    64'(out_nz),    64'(prev_nz));
                chk("stall_norm",  64'(out_norm),  64'(prev_norm));
                chk("stall_tag",   64'(out_tag),   64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got tag %0h cnt %0d, expected no output",
                             out_tag, out_cnt);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("out: tag=%0h cnt=%0d nz=%0b norm=%h", out_tag, out_cnt, out_nz, out_norm);
                    chk("out_cnt",  64'(out_cnt),  64'(e.cnt));
                    chk("out_nz",   64'(out_nz),   64'(e.nz));
                    chk("out_norm", 64'(out_norm), 64'(e.norm));
                    chk("out_tag",  64'(out_tag),  64'(e.tag));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_cnt   = out_cnt;
            prev_nz    = out_nz;
            prev_norm  = out_norm;
            prev_tag   = out_tag;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_en) out_ready = (($urandom % 4) != 0);
        end
    end

    // Holds the word until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [47:0] d, input logic [3:0] t, input exp_t e, input bit push);
        bit done = 1'b0;
        in_data  = d;
        in_tag   = t;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    logic [47:0] bp_words [4];
    int          acc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_cnt",   64'(out_cnt),   64'd0);
        chk("rst_out_nz",    64'(out_nz),    64'd0);
        chk("rst_out_norm",  64'(out_norm),  64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        @(posedge clk);
        #1;

        // Single word with latency check.
        out_ready = 1'b1;
        send(48'h0000_0001_0000, 4'd5, mk(6'd31, 1'b1, 48'h8000_0000_0000, 4'd5), 1'b1);
        @(negedge clk);
        chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
        drain("single_drain");

        // Corner words back to back.
        send(48'h8000_0000_0000, 4'd1, mk(6'd0,  1'b1, 48'h8000_0000_0000, 4'd1), 1'b1);
        send(48'h0,              4'd2, mk(6'd0,  1'b0, 48'h0,              4'd2), 1'b1);
        send(48'h1,              4'd3, mk(6'd47, 1'b1, 48'h8000_0000_0000, 4'd3), 1'b1);
        drain("corner_drain");

        // Backpressure: only two words fit with out_ready low.
        bp_words[0] = 48'h0000_0000_00F0;
        bp_words[1] = 48'h0123_4567_89AB;
        bp_words[2] = 48'h0000_8000_0000;
        bp_words[3] = 48'h4000_0000_0000;
        out_ready = 1'b0;
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            in_data  = bp_words[acc];
            in_tag   = 4'(8 + acc);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(ref_model(bp_words[acc], 4'(8 + acc)));
                acc++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 64'(acc), 64'd2);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid",    64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_data   = bp_words[2];
        in_tag    = 4'(10);
        @(negedge clk);
        chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
        if (in_ready) sb.push_back(mk(6'd16, 1'b1, 48'h8000_0000_0000, 4'd10));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("bp_drain");

        // Random streaming against the reference model.
        rand_ready_en = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            logic [63:0] tmp;
            logic [47:0] d;
            logic [3:0]  t;
            logic [2:0]  segmask;
            tmp     = {$urandom(), $urandom()};
            d       = tmp[47:0];
            segmask = 3'($urandom % 8);
            for (int s = 0; s < 3; s++) if (segmask[s]) d[s*16 +: 16] = '0;
            d = d >> ($urandom % 17);
            t = 4'($urandom % 16);
            if (($urandom % 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send(d, t, ref_model(d, t), 1'b1);
        end
        rand_ready_en = 1'b0;
        out_ready     = 1'b1;
        drain("random_drain");

        // Mid-stream reset with two words in flight.
        out_ready = 1'b0;
        send(48'h0000_0000_0003, 4'd6, mk(6'd0, 1'b0, 48'h0, 4'd0), 1'b0);
        send(48'h00FF_0000_0000, 4'd7, mk(6'd0, 1'b0, 48'h0, 4'd0), 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_cnt",   64'(out_cnt),   64'd0);
        chk("mrst_out_norm",  64'(out_norm),  64'd0);
        chk("mrst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(48'h0000_0000_0C00, 4'd12, mk(6'd36, 1'b1, 48'hC000_0000_0000, 4'd12), 1'b1);
        @(negedge clk);
        chk("mrst_lat_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("mrst_lat_cycle2", 64'(out_valid), 64'd1);
        drain("mrst_drain");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion after 3000000 ns, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
